pipe_front_ctrl: RTL and testbench
==================================

PIPE_FRONT_CTRL -- requirements
Module: pipe_front_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value after reset.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the stall and flush counters.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port stall_PC_ID, input, 1: RAW stall request; hold PC and IF/ID, insert a bubble into ID/EX.
REQ-006 Port flush_ID, input, 1: flush IF/ID.
REQ-007 Port flush_EX, input, 1: flush ID/EX.
REQ-008 Port changeFlow, input, 1: redirect the PC to branch_target.
REQ-009 Port branch_target, input, 32: redirect address.
REQ-010 Port imem_instr, input, 32: instruction fetched at pc_out.
REQ-011 Port ID_dst_reg, input, 5: destination register decoded from IF_ID_instr.
REQ-012 Port ID_reg_wen, input, 1: register-write enable decoded from IF_ID_instr.
REQ-013 Port pc_out, output, 32: current PC, used as the instruction-memory address.
REQ-014 Port IF_ID_instr, output, 32: IF/ID instruction.
REQ-015 Port IF_ID_pc, output, 32: IF/ID PC.
REQ-016 Port IF_ID_valid, output, 1: IF/ID holds a real instruction.
REQ-017 Port EX_dst_reg, output, 5: destination register of the ID/EX stage.
REQ-018 Port EX_reg_wen, output, 1: ID/EX stage will write a register.
REQ-019 Port MEM_dst_reg, output, 5: destination register of the EX/MEM stage.
REQ-020 Port MEM_reg_wen, output, 1: EX/MEM stage will write a register.
REQ-021 Port stall_cnt, output, CNT_W: saturating count of stall cycles.
REQ-022 Port flush_cnt, output, CNT_W: saturating count of cycles with flush_ID asserted.

Function
REQ-023 Next PC SHALL follow this priority: changeFlow -> branch_target; else stall_PC_ID -> hold; else pc_out+4, with the addition wrapping modulo 2^32.
REQ-024 The IF/ID register SHALL follow this priority:
- flush_ID -> IF_ID_valid=0, IF_ID_instr=NOP (32'h0), IF_ID_pc=0;
- else stall_PC_ID -> hold;
- else load imem_instr, pc_out, and valid=1.
REQ-025 The ID/EX register SHALL never hold; flush_EX or stall_PC_ID SHALL load a bubble (valid=0, reg_wen=0, dst=0); otherwise it SHALL load ID_dst_reg, ID_reg_wen & IF_ID_valid, and IF_ID_valid.
REQ-026 The EX/MEM register SHALL advance unconditionally from ID/EX every cycle.
REQ-027 EX_reg_wen SHALL equal ID/EX reg_wen AND ID/EX valid, and MEM_reg_wen SHALL be gated the same way, so invalid stages never report a write.
REQ-028 All outputs SHALL be registered values with no combinational path from any input to any output.
REQ-029 With changeFlow and stall_PC_ID both high, the redirect SHALL win for the PC and flush_ID SHALL win for IF/ID.
REQ-030 stall_cnt SHALL increment in each cycle with stall_PC_ID=1, and flush_cnt in each cycle with flush_ID=1; both SHALL saturate at all-ones and never wrap.
REQ-031 One-cycle latency: a new imem_instr SHALL appear on IF_ID_instr one cycle after capture and on EX_dst_reg two cycles after capture.
REQ-032 When a dependence is present, the inserted bubble SHALL clear it from the EX and MEM stages so that a stall lasts at most 2 consecutive cycles.

Reset
REQ-033 While rst_n=0, the block SHALL asynchronously force: pc_out=RESET_PC, all valid and reg_wen bits 0, all dst_reg 0, IF_ID_instr=NOP, IF_ID_pc=0, and both counters 0.
REQ-034 A reset asserted mid-stall or mid-redirect SHALL discard all in-flight state, and the first fetch after deassertion SHALL come from RESET_PC.

Structure
REQ-035 A shared package pipe_pkg SHALL hold NOP_INSTR, XLEN=32, REG_AW=5, and PC_STEP=4.
REQ-036 The block SHALL instantiate a sub-module pipe_stage_reg: a parameterised-width register with async reset, flush (load reset value), and hold inputs, with flush having priority over hold; it SHALL be used for IF/ID, ID/EX, and EX/MEM.

Verification
REQ-037 Straight-line fetch: after reset with RESET_PC=0 and no stall or flush for 3 cycles -> pc_out=0,4,8,12 and IF_ID_pc lags pc_out by one cycle.
REQ-038 RAW stall: stall_PC_ID=1 for 2 cycles at pc_out=8 -> pc_out holds 8 and IF/ID holds its value; EX_reg_wen=0 for 2 cycles, then fetch resumes at 12; stall_cnt=2.
REQ-039 Redirect: changeFlow=1, flush_ID=1, flush_EX=1 with branch_target=32'h40 -> next pc_out=32'h40, IF_ID_valid=0, EX_reg_wen=0; flush_cnt increments by 1.
REQ-040 Simultaneous stall and redirect: stall_PC_ID=1 with changeFlow=1 and target 32'h80 -> pc_out=32'h80 and IF_ID_valid=0.
REQ-041 Saturation: with CNT_W=4 and stall held for 20 cycles -> stall_cnt stops at 4'hF.
REQ-042 Mid-operation reset: rst_n pulsed low asynchronously during a stall -> all outputs reach their reset values immediately, and after release pc_out=RESET_PC.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared widths, constants and stage payload types for the pipeline front-end.
package pipe_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned PC_STEP = 4;

    localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(0);

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            valid;
    } if_id_t;

    typedef struct packed {
        logic [REG_AW-1:0] dst;
        logic              wen;
        logic              valid;
    } stage_t;

    localparam if_id_t IF_ID_RST = '{instr: NOP_INSTR, pc: XLEN'(0), valid: 1'b0};
    localparam stage_t STAGE_RST = '{dst: REG_AW'(0), wen: 1'b0, valid: 1'b0};

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline register: async reset, flush reloads the reset value and beats hold.
module pipe_stage_reg #(
    parameter int unsigned W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         hold_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= RST_VAL;
        end else if (flush_i) begin
            data_q <= RST_VAL;
        end else if (!hold_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_front_ctrl.sv
// Pipeline front-end: PC sequencing, IF/ID, ID/EX, EX/MEM tracking and stall/flush counters.
module pipe_front_ctrl
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_PC_ID,
    input  logic              flush_ID,
    input  logic              flush_EX,
    input  logic              changeFlow,
    input  logic [XLEN-1:0]   branch_target,
    input  logic [XLEN-1:0]   imem_instr,
    input  logic [REG_AW-1:0] ID_dst_reg,
    input  logic              ID_reg_wen,
    output logic [XLEN-1:0]   pc_out,
    output logic [XLEN-1:0]   IF_ID_instr,
    output logic [XLEN-1:0]   IF_ID_pc,
    output logic              IF_ID_valid,
    output logic [REG_AW-1:0] EX_dst_reg,
    output logic              EX_reg_wen,
    output logic [REG_AW-1:0] MEM_dst_reg,
    output logic              MEM_reg_wen,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    if_id_t           if_id_d, if_id_q;
    stage_t           id_ex_d, id_ex_q, ex_mem_q;
    logic             id_ex_flush;

    // Redirect beats stall; sequential fetch wraps modulo 2^32.
    always_comb begin
        pc_d        = pc_q + XLEN'(PC_STEP);
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (changeFlow) begin
            pc_d = branch_target;
        end else if (stall_PC_ID) begin
            pc_d = pc_q;
        end
        if (stall_PC_ID && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_ID && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Stage payloads; a stall turns the ID/EX load into a bubble.
    always_comb begin
        if_id_d       = IF_ID_RST;
        if_id_d.instr = imem_instr;
        if_id_d.pc    = pc_q;
        if_id_d.valid = 1'b1;

        id_ex_d       = STAGE_RST;
        id_ex_d.dst   = ID_dst_reg;
        id_ex_d.wen   = ID_reg_wen & if_id_q.valid;
        id_ex_d.valid = if_id_q.valid;

        id_ex_flush   = flush_EX | stall_PC_ID;
    end

    pipe_stage_reg #(
        .W       ($bits(if_id_t)),
        .RST_VAL (IF_ID_RST)
    ) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_ID),
        .hold_i  (stall_PC_ID),
        .d_i     (if_id_d),
        .q_o     (if_id_q)
    );

    pipe_stage_reg #(
        .W       ($bits(stage_t)),
        .RST_VAL (STAGE_RST)
    ) u_id_ex (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (id_ex_flush),
        .hold_i  (1'b0),
        .d_i     (id_ex_d),
        .q_o     (id_ex_q)
    );

    pipe_stage_reg #(
        .W       ($bits(stage_t)),
        .RST_VAL (STAGE_RST)
    ) u_ex_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (1'b0),
        .hold_i  (1'b0),
        .d_i     (id_ex_q),
        .q_o     (ex_mem_q)
    );

    // Write enables are masked by valid so a bubble never claims a write.
    assign pc_out      = pc_q;
    assign IF_ID_instr = if_id_q.instr;
    assign IF_ID_pc    = if_id_q.pc;
    assign IF_ID_valid = if_id_q.valid;
    assign EX_dst_reg  = id_ex_q.dst;
    assign EX_reg_wen  = id_ex_q.wen & id_ex_q.valid;
    assign MEM_dst_reg = ex_mem_q.dst;
    assign MEM_reg_wen = ex_mem_q.wen & ex_mem_q.valid;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_front_ctrl.sv
// Directed bench for pipe_front_ctrl: behavioural model feeds a scoreboard queue checked each cycle.
module tb_pipe_front_ctrl;

    localparam int unsigned CW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_PC_ID, flush_ID, flush_EX, changeFlow;
    logic [31:0] branch_target, imem_instr;
    logic [4:0]  ID_dst_reg;
    logic        ID_reg_wen;
    logic [31:0] pc_out, IF_ID_instr, IF_ID_pc;
    logic        IF_ID_valid;
    logic [4:0]  EX_dst_reg, MEM_dst_reg;
    logic        EX_reg_wen, MEM_reg_wen;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] if_instr;
        logic [31:0] if_pc;
        logic        if_valid;
        logic [4:0]  ex_dst;
        logic        ex_wen;
        logic [4:0]  mem_dst;
        logic        mem_wen;
        int          scnt;
        int          fcnt;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [31:0] m_pc, m_if_instr, m_if_pc;
    logic        m_if_valid, m_ex_wen, m_ex_valid, m_mem_wen, m_mem_valid;
    logic [4:0]  m_ex_dst, m_mem_dst;
    int          m_scnt, m_fcnt;

    pipe_front_ctrl #(.RESET_PC(32'h0), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_PC_ID   (stall_PC_ID),
        .flush_ID      (flush_ID),
        .flush_EX      (flush_EX),
        .changeFlow    (changeFlow),
        .branch_target (branch_target),
        .imem_instr    (imem_instr),
        .ID_dst_reg    (ID_dst_reg),
        .ID_reg_wen    (ID_reg_wen),
        .pc_out        (pc_out),
        .IF_ID_instr   (IF_ID_instr),
        .IF_ID_pc      (IF_ID_pc),
        .IF_ID_valid   (IF_ID_valid),
        .EX_dst_reg    (EX_dst_reg),
        .EX_reg_wen    (EX_reg_wen),
        .MEM_dst_reg   (MEM_dst_reg),
        .MEM_reg_wen   (MEM_reg_wen),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] imem(input logic [31:0] pc);
        return {16'hC0DE, 4'h0, pc[6:2], 6'h0, ~pc[2]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_if_instr = 32'h0; m_if_pc = 32'h0; m_if_valid = 1'b0;
        m_ex_dst = 5'h0; m_ex_wen = 1'b0; m_ex_valid = 1'b0;
        m_mem_dst = 5'h0; m_mem_wen = 1'b0; m_mem_valid = 1'b0;
        m_scnt = 0; m_fcnt = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pc"},       pc_out, 32'h0);
        check({tag, "_ifinstr"},  IF_ID_instr, 32'h0);
        check({tag, "_ifpc"},     IF_ID_pc, 32'h0);
        check({tag, "_ifvalid"},  32'(IF_ID_valid), 32'h0);
        check({tag, "_exdst"},    32'(EX_dst_reg), 32'h0);
        check({tag, "_exwen"},    32'(EX_reg_wen), 32'h0);
        check({tag, "_memdst"},   32'(MEM_dst_reg), 32'h0);
        check({tag, "_memwen"},   32'(MEM_reg_wen), 32'h0);
        check({tag, "_scnt"},     32'(stall_cnt), 32'h0);
        check({tag, "_fcnt"},     32'(flush_cnt), 32'h0);
    endtask

    // Drive one cycle, push the model's prediction, then pop and compare after the edge.
    task automatic step(input logic s, input logic fid, input logic fex,
                        input logic cf, input logic [31:0] tgt);
        exp_t        e, got;
        logic [31:0] n_pc, n_if_instr, n_if_pc;
        logic        n_if_valid, n_ex_wen, n_ex_valid;
        logic [4:0]  n_ex_dst;

        stall_PC_ID = s; flush_ID = fid; flush_EX = fex; changeFlow = cf;
        branch_target = tgt;
        imem_instr = imem(m_pc);
        ID_dst_reg = m_if_instr[11:7];
        ID_reg_wen = m_if_instr[0];

        n_pc = cf ? tgt : (s ? m_pc : m_pc + 32'd4);
        if (fid) begin
            n_if_instr = 32'h0; n_if_pc = 32'h0; n_if_valid = 1'b0;
        end else if (s) begin
            n_if_instr = m_if_instr; n_if_pc = m_if_pc; n_if_valid = m_if_valid;
        end else begin
            n_if_instr = imem(m_pc); n_if_pc = m_pc; n_if_valid = 1'b1;
        end
        if (fex || s) begin
            n_ex_dst = 5'h0; n_ex_wen = 1'b0; n_ex_valid = 1'b0;
        end else begin
            n_ex_dst = m_if_instr[11:7]; n_ex_wen = m_if_instr[0] & m_if_valid;
            n_ex_valid = m_if_valid;
        end
        m_mem_dst = m_ex_dst; m_mem_wen = m_ex_wen; m_mem_valid = m_ex_valid;
        m_ex_dst = n_ex_dst; m_ex_wen = n_ex_wen; m_ex_valid = n_ex_valid;
        m_pc = n_pc; m_if_instr = n_if_instr; m_if_pc = n_if_pc; m_if_valid = n_if_valid;
        if (s && m_scnt < 15) m_scnt++;
        if (fid && m_fcnt < 15) m_fcnt++;

        e.pc = m_pc; e.if_instr = m_if_instr; e.if_pc = m_if_pc; e.if_valid = m_if_valid;
        e.ex_dst = m_ex_dst; e.ex_wen = m_ex_wen & m_ex_valid;
        e.mem_dst = m_mem_dst; e.mem_wen = m_mem_wen & m_mem_valid;
        e.scnt = m_scnt; e.fcnt = m_fcnt;
        sb.push_back(e);

        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("sb_pc",      pc_out, got.pc);
        check("sb_ifinstr", IF_ID_instr, got.if_instr);
        check("sb_ifpc",    IF_ID_pc, got.if_pc);
        check("sb_ifvalid", 32'(IF_ID_valid), 32'(got.if_valid));
        check("sb_exdst",   32'(EX_dst_reg), 32'(got.ex_dst));
        check("sb_exwen",   32'(EX_reg_wen), 32'(got.ex_wen));
        check("sb_memdst",  32'(MEM_dst_reg), 32'(got.mem_dst));
        check("sb_memwen",  32'(MEM_reg_wen), 32'(got.mem_wen));
        check("sb_scnt",    32'(stall_cnt), 32'(got.scnt));
        check("sb_fcnt",    32'(flush_cnt), 32'(got.fcnt));
    endtask

    initial begin
        rst_n = 1'b0;
        stall_PC_ID = 1'b0; flush_ID = 1'b0; flush_EX = 1'b0; changeFlow = 1'b0;
        branch_target = 32'h0; imem_instr = 32'h0; ID_dst_reg = 5'h0; ID_reg_wen = 1'b0;
        model_reset();
        #1;
        check_reset_vals("rst_init");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_rel_pc", pc_out, 32'h0);

        // Straight-line fetch
        step(0, 0, 0, 0, 32'h0);
        check("line_pc4", pc_out, 32'h4);
        check("line_ifpc0", IF_ID_pc, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        check("line_pc8", pc_out, 32'h8);
        check("line_ifpc4", IF_ID_pc, 32'h4);
        check("line_exwen", 32'(EX_reg_wen), 32'h1);

        // RAW stall for two cycles at pc 8
        step(1, 0, 0, 0, 32'h0);
        check("stall1_exwen", 32'(EX_reg_wen), 32'h0);
        step(1, 0, 0, 0, 32'h0);
        check("stall2_pc", pc_out, 32'h8);
        check("stall2_ifpc", IF_ID_pc, 32'h4);
        check("stall2_exwen", 32'(EX_reg_wen), 32'h0);
        step(0, 0, 0, 0, 32'h0);
        check("resume_pc", pc_out, 32'hC);
        check("resume_ifpc", IF_ID_pc, 32'h8);
        check("resume_scnt", 32'(stall_cnt), 32'h2);

        // Redirect with both flushes
        step(0, 1, 1, 1, 32'h40);
        check("redir_pc", pc_out, 32'h40);
        check("redir_ifvalid", 32'(IF_ID_valid), 32'h0);
        check("redir_exwen", 32'(EX_reg_wen), 32'h0);
        check("redir_fcnt", 32'(flush_cnt), 32'h1);
        step(0, 0, 0, 0, 32'h0);
        check("redir_next_ifpc", IF_ID_pc, 32'h40);

        // Stall and redirect together
        step(1, 1, 0, 1, 32'h80);
        check("both_pc", pc_out, 32'h80);
        check("both_ifvalid", 32'(IF_ID_valid), 32'h0);
        repeat (3) step(0, 0, 0, 0, 32'h0);
        step(0, 0, 1, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);

        // Counter saturation
        repeat (20) step(1, 0, 0, 0, 32'h0);
        check("sat_scnt", 32'(stall_cnt), 32'hF);
        repeat (2) step(0, 0, 0, 0, 32'h0);
        repeat (16) step(0, 1, 0, 0, 32'h0);
        check("sat_fcnt", 32'(flush_cnt), 32'hF);

        // PC wrap at the top of the address space
        step(0, 1, 1, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 32'h0);
        check("wrap_pc", pc_out, 32'h0);
        check("wrap_ifpc", IF_ID_pc, 32'hFFFF_FFFC);
        repeat (3) step(0, 0, 0, 0, 32'h0);

        // Asynchronous reset in the middle of a stall
        step(1, 0, 0, 0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_async");
        stall_PC_ID = 1'b0;
        @(posedge clk);
        #1;
        check("rst_hold_pc", pc_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        check("rst_mid_rel_pc", pc_out, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        check("rst_first_fetch", IF_ID_pc, 32'h0);
        check("rst_first_valid", 32'(IF_ID_valid), 32'h1);
        repeat (2) step(0, 0, 0, 0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
